// File: rtl/johnson_seq_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : johnson_pkg
// Description : Types and helpers shared by the Johnson decoder, its code
//               checker and the Johnson counter's own model.
//               - jstate_t     : lock tracking state (HUNT/SYNC/LOCKED)
//               - PH_W         : phase index width for the default stage count
//               - johnson_next : +1 successor of a phase index, modulo 2N
// Revision    : 1.0 - initial release
// ============================================================================
package johnson_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } jstate_t;

    localparam int N_DEFAULT = 4;
    localparam int PH_W      = $clog2(2 * N_DEFAULT);

    // Successor of a phase index for an n_stages Johnson counter (2*n codes).
    function automatic int johnson_next(input int idx, input int n_stages);
        return (idx + 1) % (2 * n_stages);
    endfunction

endpackage
`default_nettype wire

// File: rtl/johnson_seq_decoder_if.sv
`default_nettype none
// ============================================================================
// Interface   : johnson_seq_decoder_if
// Description : Sample input and decoded-phase output bundle of the Johnson
//               sequence decoder.
//               master : drives in_valid/j_in, observes decoder outputs
//               slave  : the decoder itself
//               in_valid, j_in[N]            : stage sample and its qualifier
//               phase, phase_vld             : decoded index and update pulse
//               illegal, seq_err, locked     : status pulses / lock level
//               err_cnt[ERR_W]               : saturating error count
// Revision    : 1.0 - initial release
// ============================================================================
interface johnson_seq_decoder_if #(
    parameter int N     = 4,
    parameter int ERR_W = 8
);
    localparam int IDX_W = $clog2(2 * N);

    logic             in_valid;
    logic [N-1:0]     j_in;
    logic [IDX_W-1:0] phase;
    logic             phase_vld;
    logic             illegal;
    logic             seq_err;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output in_valid, j_in,
        input  phase, phase_vld, illegal, seq_err, locked, err_cnt
    );

    modport slave (
        input  in_valid, j_in,
        output phase, phase_vld, illegal, seq_err, locked, err_cnt
    );

endinterface
`default_nettype wire

// File: rtl/johnson_seq_decoder_code_check.sv
`default_nettype none
// ============================================================================
// Module      : johnson_code_check
// Description : Combinational legality check and decode of one Johnson code.
//               j_in_i[N]     : stage outputs, bit 0 = first stage
//               legal_o       : j_in_i is one of the 2N legal codes
//               idx_o[IDX_W]  : decoded phase index (meaningful when legal_o)
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter int N = 4
) (
    input  wire logic [N-1:0]             j_in_i,
    output logic                          legal_o,
    output logic [$clog2(2*N)-1:0]        idx_o
);

    localparam int IDX_W = $clog2(2 * N);

    int           pop;
    int           k;
    logic [N-1:0] pat;

    // The index is recovered from the population count alone; legality is then
    // confirmed by rebuilding the one code that maps to that index and
    // comparing, which rejects every non-contiguous pattern of the same weight.
    always_comb begin
        pop = 0;
        for (int i = 0; i < N; i++) begin
            pop = pop + int'(j_in_i[i]);
        end

        // Upper half of the cycle has the last stage set and drains from bit 0.
        if (j_in_i[N-1]) begin
            k = 2 * N - pop;
        end else begin
            k = pop;
        end

        pat = '0;
        for (int i = 0; i < N; i++) begin
            if (k <= N) begin
                pat[i] = (i < k);
            end else begin
                pat[i] = (i >= k - N);
            end
        end

        legal_o = (pat == j_in_i);
        idx_o   = IDX_W'(k);
    end

endmodule
`default_nettype wire

// File: rtl/johnson_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module      : johnson_seq_decoder
// Description : Receive side of an N-stage Johnson counter. Samples the stage
//               outputs, checks legality, decodes to a phase index, verifies
//               +1 succession and tracks lock.
//               clk  : clock, rising edge
//               rst  : asynchronous active-high reset
//               bus  : johnson_seq_decoder_if.slave (sample in, status out)
// Parameters  : N        - Johnson stages (2N legal codes), N >= 2
//               LOCK_CNT - consecutive good steps needed for lock, >= 1
//               ERR_W    - saturating error counter width
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_seq_decoder
    import johnson_pkg::*;
#(
    parameter int N        = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    johnson_seq_decoder_if.slave   bus
);

    localparam int IDX_W = $clog2(2 * N);
    localparam int GC_W  = $clog2(LOCK_CNT + 1);

    // ------------------------------------------------------------------------
    // Decode of the current sample
    // ------------------------------------------------------------------------
    logic             code_legal;
    logic [IDX_W-1:0] code_idx;

    johnson_code_check #(
        .N (N)
    ) u_code_check (
        .j_in_i  (bus.j_in),
        .legal_o (code_legal),
        .idx_o   (code_idx)
    );

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    jstate_t          state_q;
    logic             have_prev_q;
    logic [IDX_W-1:0] prev_q;
    logic [GC_W-1:0]  good_q;
    logic [IDX_W-1:0] phase_q;
    logic             phase_vld_q;
    logic             illegal_q;
    logic             seq_err_q;
    logic             locked_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [ERR_W-1:0] err_cnt_d;

    logic seq_bad;
    logic err_inc;

    // Without a previous sample there is nothing to compare against, so the
    // first legal code after reset or after an illegal one is always accepted.
    assign seq_bad = have_prev_q &&
                     (int'(code_idx) != johnson_next(int'(prev_q), N));

    // Illegal and seq_err are mutually exclusive, so at most one increment.
    assign err_inc = bus.in_valid && (!code_legal || seq_bad);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Sample stage, lock FSM and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
            good_q      <= '0;
            phase_q     <= '0;
            phase_vld_q <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            locked_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            phase_vld_q <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;

            if (bus.in_valid) begin
                if (!code_legal) begin
                    // Lose all history: the next legal code re-seeds.
                    illegal_q   <= 1'b1;
                    have_prev_q <= 1'b0;
                    good_q      <= '0;
                    state_q     <= HUNT;
                    locked_q    <= 1'b0;
                end else begin
                    phase_q     <= code_idx;
                    phase_vld_q <= 1'b1;
                    seq_err_q   <= seq_bad;
                    prev_q      <= code_idx;
                    have_prev_q <= 1'b1;

                    case (state_q)
                        HUNT: begin
                            state_q  <= SYNC;
                            good_q   <= '0;
                            locked_q <= 1'b0;
                        end
                        SYNC: begin
                            if (seq_bad) begin
                                good_q <= '0;
                            end else if (int'(good_q) + 1 >= LOCK_CNT) begin
                                // Lock is reported alongside the phase that
                                // completed the run of good steps.
                                good_q   <= GC_W'(LOCK_CNT);
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                good_q <= good_q + GC_W'(1);
                            end
                        end
                        LOCKED: begin
                            if (seq_bad) begin
                                state_q  <= SYNC;
                                good_q   <= '0;
                                locked_q <= 1'b0;
                            end
                        end
                        default: begin
                            state_q  <= HUNT;
                            good_q   <= '0;
                            locked_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.phase     = phase_q;
    assign bus.phase_vld = phase_vld_q;
    assign bus.illegal   = illegal_q;
    assign bus.seq_err   = seq_err_q;
    assign bus.locked    = locked_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_johnson_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_johnson_seq_decoder
// Description : Scoreboard bench for johnson_seq_decoder. Two decoders (ERR_W
//               8 and 2) receive identical samples; a reference model built
//               from a simulated Johnson shift register predicts each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_johnson_seq_decoder;

    localparam int TN   = 4;
    localparam int LOCK = 3;

    typedef struct {
        int    phase;
        bit    vld;
        bit    ill;
        bit    seq;
        bit    locked;
        int    err;
        string tag;
    } exp_t;

    logic clk;
    logic rst;

    johnson_seq_decoder_if #(.N(TN), .ERR_W(8)) if0 ();
    johnson_seq_decoder_if #(.N(TN), .ERR_W(2)) if1 ();

    johnson_seq_decoder #(.N(TN), .LOCK_CNT(LOCK), .ERR_W(8)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    johnson_seq_decoder #(.N(TN), .LOCK_CNT(LOCK), .ERR_W(2)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    exp_t exp_q[$];

    // Code table generated by running a Johnson counter from all-zeros:
    // shift toward the last stage, first stage fed by the inverted last stage.
    logic [TN-1:0] tbl[2*TN];

    // Reference model state
    int m_phase, m_prev, m_good, m_mode, m_err;
    bit m_have;
    int cur;

    task automatic model_reset();
        m_phase = 0; m_prev = 0; m_good = 0; m_mode = 0; m_err = 0; m_have = 0;
    endtask

    task automatic check_out(input string nm, input string tag,
                             input logic [2:0] ph, input logic v, input logic il,
                             input logic sq, input logic lk, input int ec,
                             input exp_t e, input int errmax);
        int ee;
        ee = (e.err > errmax) ? errmax : e.err;
        tests++;
        if (ph !== 3'(e.phase) || v !== e.vld || il !== e.ill ||
            sq !== e.seq || lk !== e.locked || ec != ee) begin
            failed++;
            $display("FAIL %s/%s: got ph=%0d vld=%b ill=%b seq=%b lk=%b err=%0d, exp ph=%0d vld=%b ill=%b seq=%b lk=%b err=%0d",
                     nm, tag, ph, v, il, sq, lk, ec,
                     e.phase, e.vld, e.ill, e.seq, e.locked, ee);
        end
    endtask

    task automatic check_both(input string tag, input exp_t e);
        check_out("dut0", tag, if0.phase, if0.phase_vld, if0.illegal, if0.seq_err,
                  if0.locked, int'(if0.err_cnt), e, 255);
        check_out("dut1", tag, if1.phase, if1.phase_vld, if1.illegal, if1.seq_err,
                  if1.locked, int'(if1.err_cnt), e, 3);
    endtask

    // Monitor: every cycle with a pending expectation is checked 1 time unit
    // after the rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_both(e.tag, e);
        end
    end

    task automatic drive(input bit v, input logic [TN-1:0] code);
        if0.in_valid = v; if0.j_in = code;
        if1.in_valid = v; if1.j_in = code;
    endtask

    // One stimulus cycle: drive on the falling edge, predict, enqueue.
    task automatic step(input bit v, input logic [TN-1:0] code, input string tag);
        exp_t e;
        int   k;
        bit   bad;
        @(negedge clk);
        drive(v, code);
        e.vld = 0; e.ill = 0; e.seq = 0;
        if (v) begin
            k = -1;
            for (int i = 0; i < 2*TN; i++) if (tbl[i] == code) k = i;
            if (k < 0) begin
                e.ill  = 1;
                m_have = 0;
                m_good = 0;
                m_mode = 0;
                m_err++;
            end else begin
                bad     = m_have && (k != (m_prev + 1) % (2*TN));
                e.vld   = 1;
                e.seq   = bad;
                m_phase = k;
                if (bad) m_err++;
                if (m_mode == 0) begin
                    m_mode = 1; m_good = 0;
                end else if (m_mode == 1) begin
                    if (bad) m_good = 0;
                    else begin
                        m_good++;
                        if (m_good >= LOCK) m_mode = 2;
                    end
                end else if (bad) begin
                    m_mode = 1; m_good = 0;
                end
                m_prev = k;
                m_have = 1;
                cur    = k;
            end
        end
        e.phase  = m_phase;
        e.locked = (m_mode == 2);
        e.err    = m_err;
        e.tag    = tag;
        exp_q.push_back(e);
    endtask

    task automatic send(input int k, input string tag);
        step(1'b1, tbl[k], tag);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        exp_t z;
        @(negedge clk);
        drive(1'b0, '0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        z.phase = 0; z.vld = 0; z.ill = 0; z.seq = 0; z.locked = 0; z.err = 0;
        check_both(tag, z);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TN-1:0] c;
        exp_t          z;
        int            r;

        c = '0;
        for (int i = 0; i < 2*TN; i++) begin
            tbl[i] = c;
            c = {c[TN-2:0], ~c[TN-1]};
        end

        model_reset();
        cur = 0;
        rst = 1'b1;
        drive(1'b0, '0);
        #1;
        z.phase = 0; z.vld = 0; z.ill = 0; z.seq = 0; z.locked = 0; z.err = 0;
        check_both("reset_state", z);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 2*TN; k++) send(k, "seq_0_to_7");
        send(0, "wrap");
        send(1, "locked_1");
        send(2, "locked_2");
        send(4, "inject_skip");
        send(5, "resync_5");
        send(6, "resync_6");
        send(7, "relock_7");
        step(1'b1, 4'b0101, "illegal_0101");
        send(2, "after_illegal");
        send(3, "hunt_3");
        send(4, "hunt_4");
        for (int i = 0; i < 5; i++) step(1'b0, 4'b1010, "idle");
        send(5, "resume_5");
        send(6, "resume_6");
        send(7, "resume_7");
        send(0, "resume_0");
        step(1'b1, 4'b0101, "sat_ill");
        step(1'b1, 4'b1010, "sat_ill");
        step(1'b1, 4'b0100, "sat_ill");
        step(1'b1, 4'b1011, "sat_ill");
        step(1'b1, 4'b1101, "sat_ill");
        for (int k = 0; k < 4; k++) send(k, "lock_again");
        async_reset("async_reset");
        send(6, "post_reset_first");
        send(7, "post_reset_second");

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      send((cur + 1) % (2*TN), "rand_next");
            else if (r < 75) send($urandom_range(0, 2*TN-1), "rand_legal");
            else if (r < 85) step(1'b1, 4'($urandom_range(0, 15)), "rand_raw");
            else             step(1'b0, 4'($urandom_range(0, 15)), "rand_idle");
        end

        @(negedge clk);
        drive(1'b0, '0);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
